mul_seq: RTL and testbench

- Parametrised iterative shift-add multiplier; next generation of the team's single-cycle registered multiplier.
- Operand widths are generic and there is a per-transaction signed/unsigned mode.
- Ready/valid handshakes on input and output.
- Trades latency (one cycle per multiplier bit) for area.
- Sits between operand producers and datapath consumers that tolerate multi-cycle results and backpressure.

---
 rtl/mul_seq.sv | 143 ++++++++++++++
 tb/tb_mul_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// ============================================================================
// Module      : mul_seq
// Description : Iterative shift-add multiplier, one multiplier bit per cycle,
//               with signed/unsigned mode and ready/valid handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq #(
    parameter  int A_W   = 4,
    parameter  int B_W   = 3,
    localparam int C_W   = A_W + B_W,
    localparam int CNT_W = $clog2(B_W) + 1
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   mul_a,
    input  logic [B_W-1:0]   mul_b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [C_W-1:0]   mul_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(B_W - 1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [C_W-1:0]     mcand_q,     mcand_d;
    logic [B_W-1:0]     mplier_q,    mplier_d;
    logic               neg_q,       neg_d;
    logic [C_W-1:0]     acc_q,       acc_d;
    logic [C_W-1:0]     result_q,    result_d;
    logic               out_valid_q, out_valid_d;

    logic [A_W-1:0]     w_a_mag;
    logic [B_W-1:0]     w_b_mag;
    logic [C_W-1:0]     w_acc_sum;
    logic               w_last_bit;

    // Magnitudes are kept unsigned so the most negative operand fits exactly.
    always_comb begin
        w_a_mag = mul_a;
        w_b_mag = mul_b;
        if (signed_mode && mul_a[A_W-1]) begin
            w_a_mag = (~mul_a) + A_W'(1);
        end
        if (signed_mode && mul_b[B_W-1]) begin
            w_b_mag = (~mul_b) + B_W'(1);
        end
    end

    // The multiplicand shifts left and the multiplier shifts right each step,
    // so the current multiplier bit is always mplier_q[0].
    assign w_acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_last_bit = (cnt_q == C_LAST_BIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{B_W{1'b0}}, w_a_mag};
                    mplier_d = w_b_mag;
                    neg_d    = signed_mode & (mul_a[A_W-1] ^ mul_b[B_W-1]);
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = S_CALC;
                end
            end

            S_CALC: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (w_last_bit) begin
                    result_d    = neg_q ? ((~w_acc_sum) + C_W'(1)) : w_acc_sum;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign mul_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
// Module      : tb_mul_seq
// Description : Self-checking bench for mul_seq: directed corners plus
//               randomized handshakes scored against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

    localparam int A_W = 4;
    localparam int B_W = 3;
    localparam int C_W = A_W + B_W;
    localparam int N_RANDOM = 1000;

    logic             sysclk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   mul_a;
    logic [B_W-1:0]   mul_b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [C_W-1:0]   mul_result;

    int n_vec = 0;
    int n_err = 0;

    mul_seq #(.A_W(A_W), .B_W(B_W)) u_dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .mul_result  (mul_result)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Reference product: interpret operands as integers, multiply, keep C_W bits.
    function automatic logic [C_W-1:0] model(input logic [A_W-1:0] a,
                                             input logic [B_W-1:0] b,
                                             input logic s);
        int ai;
        int bi;
        int p;
        ai = int'(a);
        bi = int'(b);
        if (s && a[A_W-1]) ai -= (1 << A_W);
        if (s && b[B_W-1]) bi -= (1 << B_W);
        p = ai * bi;
        return p[C_W-1:0];
    endfunction

    task automatic run_txn(input string tag, input logic [A_W-1:0] a,
                           input logic [B_W-1:0] b, input logic s, input int hold);
        logic [C_W-1:0] exp;
        exp = model(a, b, s);
        check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        mul_a       = a;
        mul_b       = b;
        signed_mode = s;
        in_valid    = 1'b1;
        out_ready   = (hold == 0);
        tick();
        in_valid    = 1'b0;
        mul_a       = A_W'($urandom);
        mul_b       = B_W'($urandom);
        signed_mode = 1'($urandom);
        check({tag, "_ready_drop"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < B_W; k++) begin
            check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
            tick();
        end
        check({tag, "_valid_rise"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(mul_result), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_result"}, 32'(mul_result), 32'(exp));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_result_kept"}, 32'(mul_result), 32'(exp));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [C_W-1:0] q[$];
        logic           prev_stall;
        logic [C_W-1:0] prev_res;
        logic [C_W-1:0] exp_front;
        int             accepted;
        int             received;
        int             cyc;

        rst         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        signed_mode = 1'b0;

        // Reset takes effect between clock edges.
        #2 rst = 1'b1;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(mul_result), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        run_txn("unsigned_max", 4'd15, 3'd7, 1'b0, 0);
        run_txn("signed_m8xm4", 4'b1000, 3'b100, 1'b1, 0);
        run_txn("signed_7xm4", 4'd7, 3'b100, 1'b1, 0);
        run_txn("signed_m1x1", 4'b1111, 3'd1, 1'b1, 0);
        run_txn("signed_zero", 4'd0, 3'b101, 1'b1, 0);
        run_txn("backpressure", 4'd3, 3'd5, 1'b0, 10);

        // Abort a transaction one CALC edge after acceptance.
        mul_a       = 4'd9;
        mul_b       = 3'd6;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midcalc_rst_valid", 32'(out_valid), 32'd0);
        check("midcalc_rst_result", 32'(mul_result), 32'd0);
        check("midcalc_rst_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2 * B_W; k++) begin
            tick();
            check("midcalc_no_result", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        run_txn("after_rst", 4'd2, 3'd3, 1'b0, 0);

        // Randomized handshakes; at most one product in flight at a time.
        accepted   = 0;
        received   = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_res   = '0;
        while ((accepted < N_RANDOM || q.size() > 0) && cyc < 60000) begin
            in_valid    = (accepted < N_RANDOM) && ($urandom_range(0, 3) != 0);
            mul_a       = A_W'($urandom);
            mul_b       = B_W'($urandom);
            signed_mode = 1'($urandom);
            out_ready   = 1'($urandom);
            if (prev_stall) begin
                check("rnd_hold_valid", 32'(out_valid), 32'd1);
                check("rnd_hold_result", 32'(mul_result), 32'(prev_res));
            end
            if (in_valid && in_ready) begin
                q.push_back(model(mul_a, mul_b, signed_mode));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_result", 32'd1, 32'd0);
                end else begin
                    exp_front = q.pop_front();
                    check("rnd_product", 32'(mul_result), 32'(exp_front));
                end
                received++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = mul_result;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_received_count", 32'(received), 32'(N_RANDOM));
        check("rnd_queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
